prv32_alu_mdu: RTL and testbench

Parametrised multi-cycle execute unit for the pipelined RV32 core. Handles two classes of operation:
- single-cycle base integer ops, using the existing 4-bit ALU function encoding;
- the RV32M multiply/divide ops, executed iteratively.

It sits in the EX stage. The hazard unit stalls the pipeline while `busy` is high, and the EX/MEM register captures `result` when `done` pulses.

---
 rtl/prv32_pkg.sv | 40 ++++
 rtl/prv32_alu_base.sv | 53 +++++
 rtl/prv32_alu_mdu.sv | 166 ++++++++++++++++
 tb/tb_prv32_alu_mdu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prv32_pkg.sv
// Shared definitions for the RV32 execute stage: base ALU function codes,
// RV32M funct3 codes and the multi-cycle unit's state encoding.
package prv32_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_PASSB = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLTU  = 4'd10;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/prv32_alu_base.sv
// Combinational single-cycle integer datapath: adder/subtractor with flags,
// logic ops, barrel shifts and set-less-than.
module prv32_alu_base
  import prv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         a_i,
  input  logic [XLEN-1:0]         b_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  input  logic [3:0]              alufn_i,
  output logic [XLEN-1:0]         result_o,
  output logic                    cf_o,
  output logic                    zf_o,
  output logic                    vf_o,
  output logic                    sf_o
);

  logic            sub;
  logic [XLEN-1:0] b_eff;
  logic [XLEN-1:0] sum;
  logic            carry;
  logic            ovf;

  // The comparisons reuse the subtractor, so their flags reflect a - b.
  assign sub   = (alufn_i == ALU_SUB) || (alufn_i == ALU_SLT) || (alufn_i == ALU_SLTU);
  assign b_eff = sub ? ~b_i : b_i;
  assign {carry, sum} = {1'b0, a_i} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
  assign ovf   = (a_i[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);

  assign cf_o = carry;
  assign zf_o = (sum == '0);
  assign vf_o = ovf;
  assign sf_o = sum[XLEN-1];

  always_comb begin
    result_o = '0;
    case (alufn_i)
      ALU_ADD, ALU_SUB: result_o = sum;
      ALU_PASSB:        result_o = b_i;
      ALU_OR:           result_o = a_i | b_i;
      ALU_AND:          result_o = a_i & b_i;
      ALU_XOR:          result_o = a_i ^ b_i;
      ALU_SLL:          result_o = a_i << shamt_i;
      ALU_SRL:          result_o = a_i >> shamt_i;
      ALU_SRA:          result_o = $unsigned($signed(a_i) >>> shamt_i);
      ALU_SLT:          result_o = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ ovf};
      ALU_SLTU:         result_o = {{(XLEN-1){1'b0}}, ~carry};
      default:          result_o = '0;
    endcase
  end

endmodule

// File: rtl/prv32_alu_mdu.sv
// EX-stage execute unit: single-cycle base ops plus iterative RV32M
// multiply (radix-2 shift-add) and divide (restoring) with sign fix-up.
module prv32_alu_mdu
  import prv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sel_md,
  input  logic [3:0]              alufn,
  input  logic [2:0]              md_op,
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic                    kill,
  output logic                    busy,
  output logic                    done,
  output logic [XLEN-1:0]         result,
  output logic                    cf,
  output logic                    zf,
  output logic                    vf,
  output logic                    sf
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_ONE = 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;
  logic              cf_q, zf_q, vf_q, sf_q;
  logic [2:0]        md_op_q;
  logic              neg_res_q;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;

  logic [XLEN-1:0] base_res;
  logic            base_cf, base_zf, base_vf, base_sf;

  prv32_alu_base #(.XLEN(XLEN)) u_base (
    .a_i      (a),
    .b_i      (b),
    .shamt_i  (shamt),
    .alufn_i  (alufn),
    .result_o (base_res),
    .cf_o     (base_cf),
    .zf_o     (base_zf),
    .vf_o     (base_vf),
    .sf_o     (base_sf)
  );

  logic            neg_a, neg_b, is_div, b_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign neg_a   = md_a_signed(md_op) & a[XLEN-1];
  assign neg_b   = md_b_signed(md_op) & b[XLEN-1];
  assign mag_a   = neg_a ? -a : a;
  assign mag_b   = neg_b ? -b : b;
  assign is_div  = md_op[2];
  assign b_zero  = (b == '0);
  assign div_ovf = is_div && !md_op[0] && (a == MIN_VAL) && (b == '1);
  // md_op[1] distinguishes REM/REMU from DIV/DIVU.
  assign special_res = md_op[1] ? (b_zero ? a : '0) : (b_zero ? '1 : MIN_VAL);

  logic [XLEN:0] mul_sum, div_trial, div_diff;

  // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  // Lower half of acc_q shifts the dividend out and the quotient in.
  assign div_trial = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, opb_q};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_res_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = rem_fix;
    case (md_op_q)
      MD_MUL:                        fix_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               fix_res = quot_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      {cf_q, zf_q, vf_q, sf_q} <= 4'b0000;
      md_op_q   <= '0;
      neg_res_q <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
    end else if (kill) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!sel_md) begin
              result_q <= base_res;
              {cf_q, zf_q, vf_q, sf_q} <= {base_cf, base_zf, base_vf, base_sf};
              done_q   <= 1'b1;
            end else if (is_div && (b_zero || div_ovf)) begin
              result_q <= special_res;
              done_q   <= 1'b1;
            end else begin
              md_op_q   <= md_op;
              // The remainder follows the dividend's sign; everything else the product of signs.
              neg_res_q <= (is_div && md_op[1]) ? neg_a : (neg_a ^ neg_b);
              opb_q     <= mag_b;
              acc_q     <= {{XLEN{1'b0}}, mag_a};
              rem_q     <= '0;
              cnt_q     <= CW'(XLEN);
              busy_q    <= 1'b1;
              state_q   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (md_op_q[2]) begin
            rem_q <= div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];
            acc_q[XLEN-1:0] <= {acc_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            acc_q <= {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cf     = cf_q;
  assign zf     = zf_q;
  assign vf     = vf_q;
  assign sf     = sf_q;

endmodule

// File: tb/tb_prv32_alu_mdu.sv
// Directed table-driven bench for prv32_alu_mdu (XLEN=32) plus a randomised
// RV32M sweep of an XLEN=8 instance against a behavioural model.
module tb_prv32_alu_mdu;
  import prv32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, sel_md, kill;
  logic [3:0]  alufn;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, cf, zf, vf, sf;
  logic [31:0] result;

  logic        start8, sel_md8, kill8;
  logic [3:0]  alufn8;
  logic [2:0]  md_op8;
  logic [7:0]  a8, b8;
  logic [2:0]  shamt8;
  logic        busy8, done8, cf8, zf8, vf8, sf8;
  logic [7:0]  result8;

  prv32_alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_md(sel_md), .alufn(alufn),
    .md_op(md_op), .a(a), .b(b), .shamt(shamt), .kill(kill),
    .busy(busy), .done(done), .result(result),
    .cf(cf), .zf(zf), .vf(vf), .sf(sf)
  );

  prv32_alu_mdu #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sel_md(sel_md8), .alufn(alufn8),
    .md_op(md_op8), .a(a8), .b(b8), .shamt(shamt8), .kill(kill8),
    .busy(busy8), .done(done8), .result(result8),
    .cf(cf8), .zf(zf8), .vf(vf8), .sf(sf8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sel;
    logic [3:0]  fn;
    logic [2:0]  op;
    logic [31:0] av;
    logic [31:0] bv;
    logic [4:0]  sh;
    logic [31:0] exp;
    int          lat;
    logic [3:0]  fl;   // {cf,zf,vf,sf}, meaningful for base ops only
  } vec_t;

  localparam int NV = 28;
  vec_t vt[NV];

  task automatic op32(input logic s, input logic [3:0] fn, input logic [2:0] op,
                      input logic [31:0] av, input logic [31:0] bv, input logic [4:0] sh,
                      output int lat, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; sel_md = s; alufn = fn; md_op = op; a = av; b = bv; shamt = sh;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
    lat = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic op8(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                     output int lat, output logic [7:0] res);
    @(negedge clk);
    start8 = 1'b1; md_op8 = op; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    res = result8;
  endtask

  function automatic logic [7:0] model8(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    int sx, sy, ux, uy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    case (op)
      MD_MUL:    r = ux * uy;
      MD_MULH:   r = (sx * sy) >>> 8;
      MD_MULHSU: r = (sx * uy) >>> 8;
      MD_MULHU:  r = (ux * uy) >> 8;
      MD_DIV:    r = (y == 0) ? -1 : ((x == 8'h80 && y == 8'hFF) ? sx : sx / sy);
      MD_DIVU:   r = (y == 0) ? -1 : ux / uy;
      MD_REM:    r = (y == 0) ? sx : ((x == 8'h80 && y == 8'hFF) ? 0 : sx % sy);
      default:   r = (y == 0) ? ux : ux % uy;
    endcase
    return r[7:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [31:0] res;
    logic [7:0]  res8;
    logic [3:0]  last_fl;
    logic [31:0] last_res;
    logic [3:0]  exp_fl;

    rst = 1'b1; start = 1'b0; sel_md = 1'b0; kill = 1'b0; alufn = '0; md_op = '0;
    a = '0; b = '0; shamt = '0;
    start8 = 1'b0; sel_md8 = 1'b1; kill8 = 1'b0; alufn8 = '0; md_op8 = '0;
    a8 = '0; b8 = '0; shamt8 = '0;

    vt[0]  = '{1'b0, ALU_ADD,   3'd0,      32'd5,          32'd7,          5'd0,  32'd12,         1,  4'b0000};
    vt[1]  = '{1'b0, ALU_SUB,   3'd0,      32'd7,          32'd7,          5'd0,  32'd0,          1,  4'b1100};
    vt[2]  = '{1'b0, ALU_SUB,   3'd0,      32'h7FFF_FFFF,  32'hFFFF_FFFF,  5'd0,  32'h8000_0000,  1,  4'b0011};
    vt[3]  = '{1'b0, ALU_ADD,   3'd0,      32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1,  4'b1100};
    vt[4]  = '{1'b0, ALU_SRA,   3'd0,      32'h8000_0000,  32'd0,          5'd4,  32'hF800_0000,  1,  4'b0001};
    vt[5]  = '{1'b0, ALU_SLL,   3'd0,      32'd1,          32'd0,          5'd31, 32'h8000_0000,  1,  4'b0000};
    vt[6]  = '{1'b0, ALU_SRL,   3'd0,      32'h8000_0000,  32'd0,          5'd31, 32'd1,          1,  4'b0001};
    vt[7]  = '{1'b0, ALU_SLT,   3'd0,      32'hFFFF_FFFF,  32'd1,          5'd0,  32'd1,          1,  4'b1001};
    vt[8]  = '{1'b0, ALU_SLTU,  3'd0,      32'hFFFF_FFFF,  32'd1,          5'd0,  32'd0,          1,  4'b1001};
    vt[9]  = '{1'b0, ALU_XOR,   3'd0,      32'hF0F0_F0F0,  32'hFF00_FF00,  5'd0,  32'h0FF0_0FF0,  1,  4'b1001};
    vt[10] = '{1'b0, ALU_PASSB, 3'd0,      32'd0,          32'h1234_5678,  5'd0,  32'h1234_5678,  1,  4'b0000};
    vt[11] = '{1'b1, 4'd0,      MD_MUL,    32'hFFFF_FFFF,  32'd3,          5'd0,  32'hFFFF_FFFD,  34, 4'b0000};
    vt[12] = '{1'b1, 4'd0,      MD_MULH,   32'hFFFF_FFFF,  32'd3,          5'd0,  32'hFFFF_FFFF,  34, 4'b0000};
    vt[13] = '{1'b1, 4'd0,      MD_MULHU,  32'hFFFF_FFFF,  32'd3,          5'd0,  32'h0000_0002,  34, 4'b0000};
    vt[14] = '{1'b1, 4'd0,      MD_MULHSU, 32'hFFFF_FFFF,  32'd3,          5'd0,  32'hFFFF_FFFF,  34, 4'b0000};
    vt[15] = '{1'b1, 4'd0,      MD_DIV,    32'hFFFF_FFF9,  32'd2,          5'd0,  32'hFFFF_FFFD,  34, 4'b0000};
    vt[16] = '{1'b1, 4'd0,      MD_REM,    32'hFFFF_FFF9,  32'd2,          5'd0,  32'hFFFF_FFFF,  34, 4'b0000};
    vt[17] = '{1'b1, 4'd0,      MD_DIVU,   32'hFFFF_FFF9,  32'd2,          5'd0,  32'h7FFF_FFFC,  34, 4'b0000};
    vt[18] = '{1'b1, 4'd0,      MD_REMU,   32'hFFFF_FFF9,  32'd2,          5'd0,  32'd1,          34, 4'b0000};
    vt[19] = '{1'b1, 4'd0,      MD_DIV,    32'd42,         32'd0,          5'd0,  32'hFFFF_FFFF,  1,  4'b0000};
    vt[20] = '{1'b1, 4'd0,      MD_REM,    32'd42,         32'd0,          5'd0,  32'd42,         1,  4'b0000};
    vt[21] = '{1'b1, 4'd0,      MD_DIVU,   32'd42,         32'd0,          5'd0,  32'hFFFF_FFFF,  1,  4'b0000};
    vt[22] = '{1'b1, 4'd0,      MD_REMU,   32'd42,         32'd0,          5'd0,  32'd42,         1,  4'b0000};
    vt[23] = '{1'b1, 4'd0,      MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd0,  32'h8000_0000,  1,  4'b0000};
    vt[24] = '{1'b1, 4'd0,      MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd0,  32'd0,          1,  4'b0000};
    vt[25] = '{1'b1, 4'd0,      MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  5'd0,  32'd0,          34, 4'b0000};
    vt[26] = '{1'b1, 4'd0,      MD_MUL,    32'h1234_5678,  32'h0000_0010,  5'd0,  32'h2345_6780,  34, 4'b0000};
    vt[27] = '{1'b1, 4'd0,      MD_REM,    32'd7,          32'hFFFF_FFFE,  5'd0,  32'd1,          34, 4'b0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset result", result, 32'd0);
    check("reset busy/done", {30'd0, busy, done}, 32'd0);
    check("reset flags", {28'd0, cf, zf, vf, sf}, 32'd0);
    check("reset result8", {24'd0, result8}, 32'd0);
    rst = 1'b0;
    last_fl = 4'b0000;

    // Table-driven directed vectors
    for (int i = 0; i < NV; i++) begin
      op32(vt[i].sel, vt[i].fn, vt[i].op, vt[i].av, vt[i].bv, vt[i].sh, lat, res);
      if (!vt[i].sel) last_fl = vt[i].fl;
      exp_fl = last_fl;
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("vec%0d result", i), res, vt[i].exp);
      check($sformatf("vec%0d flags", i), {28'd0, cf, zf, vf, sf}, {28'd0, exp_fl});
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), {31'd0, done}, 32'd0);
      $display("vec %0d: sel=%0d fn=%0d op=%0d a=0x%h b=0x%h -> result=0x%h lat=%0d",
               i, vt[i].sel, vt[i].fn, vt[i].op, vt[i].av, vt[i].bv, res, lat);
    end

    // Busy profile of an iterative op, ignored start while busy, back-to-back start on done
    @(negedge clk);
    start = 1'b1; sel_md = 1'b1; md_op = MD_MULHU; a = 32'hFFFF_FFFF; b = 32'd3;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      check($sformatf("seq1 busy c%0d", c), {31'd0, busy}, {31'd0, (c >= 1 && c <= 33)});
      check($sformatf("seq1 done c%0d", c), {31'd0, done}, {31'd0, (c == 34 || c == 35)});
      if (c == 34) check("seq1 MULHU result", result, 32'd2);
      if (c == 35) check("seq1 back-to-back ADD result", result, 32'd5);
      start = 1'b0;
      if (c == 5) begin
        start = 1'b1; sel_md = 1'b0; alufn = ALU_ADD; a = 32'd1; b = 32'd1;
      end
      if (c == 34) begin
        start = 1'b1; sel_md = 1'b0; alufn = ALU_ADD; a = 32'd2; b = 32'd3;
      end
    end
    last_fl  = 4'b0000;
    last_res = 32'd5;
    $display("seq1: MULHU busy profile with back-to-back ADD -> result=0x%h", result);

    // Kill mid-divide, together with a start in the same cycle
    @(negedge clk);
    start = 1'b1; sel_md = 1'b1; md_op = MD_DIVU; a = 32'd100; b = 32'd3;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      check($sformatf("seq2 busy c%0d", c), {31'd0, busy}, {31'd0, (c <= 10)});
      check($sformatf("seq2 done c%0d", c), {31'd0, done}, 32'd0);
      start = (c == 10);
      kill  = (c == 10);
      sel_md = 1'b0; alufn = ALU_ADD; a = 32'd1; b = 32'd1;
    end
    check("seq2 result kept", result, last_res);
    check("seq2 flags kept", {28'd0, cf, zf, vf, sf}, {28'd0, last_fl});
    $display("seq2: DIVU killed at cycle 10 -> result=0x%h", result);

    // Reset during RUN
    @(negedge clk);
    start = 1'b1; sel_md = 1'b1; md_op = MD_MUL; a = 32'h1234; b = 32'h10;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (c == 5);
    end
    check("seq3 result after rst", result, 32'd0);
    check("seq3 busy/done after rst", {30'd0, busy, done}, 32'd0);
    check("seq3 flags after rst", {28'd0, cf, zf, vf, sf}, 32'd0);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) check("seq3 done after rst", {31'd0, done}, 32'd0);
    end
    op32(1'b0, ALU_ADD, 3'd0, 32'd5, 32'd7, 5'd0, lat, res);
    check("seq3 post-reset ADD", res, 32'd12);
    $display("seq3: reset mid-RUN, then ADD -> result=0x%h", res);

    // XLEN=8 RV32M sweep against the behavioural model
    for (int i = 0; i < 32; i++) begin
      logic [2:0] op;
      logic [7:0] av, bv, ex;
      int         elat;
      op = 3'($urandom_range(0, 7));
      av = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       bv = 8'h00;
        1:       bv = 8'hFF;
        default: bv = 8'($urandom);
      endcase
      if (i == 1) begin op = MD_DIV; av = 8'h80; bv = 8'hFF; end
      if (i == 2) begin op = MD_REM; av = 8'h80; bv = 8'hFF; end
      if (i == 3) begin op = MD_MULH; av = 8'h80; bv = 8'h80; end
      ex   = model8(op, av, bv);
      elat = (op[2] && (bv == 8'h00 || (!op[0] && av == 8'h80 && bv == 8'hFF))) ? 1 : 10;
      op8(op, av, bv, lat, res8);
      check($sformatf("x8 %0d latency", i), 32'(lat), 32'(elat));
      check($sformatf("x8 %0d result", i), {24'd0, res8}, {24'd0, ex});
      check($sformatf("x8 %0d busy", i), {31'd0, busy8}, 32'd0);
      $display("x8 %0d: op=%0d a=0x%h b=0x%h -> result=0x%h lat=%0d", i, op, av, bv, res8, lat);
    end
    check("x8 flags untouched by M ops", {28'd0, cf8, zf8, vf8, sf8}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
